hazard_fwd_unit: RTL and testbench
==================================

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 id_valid  input  1  decode stage holds a real instruction.
REQ-004 id_rs1 / id_rs2  input  5 each  source register indices of the decode-stage instruction.
REQ-005 id_rd  input  5  destination index of the decode-stage instruction.
REQ-006 id_regWrite / id_memRead  input  1 each  decode-stage instruction writes the register file / is a load.
REQ-007 ex_branchTaken  input  1  branch or jump resolved taken in execute this cycle.
REQ-008 forwardA / forwardB  output  2 each  operand select for execute: 00 register file, 01 writeback result, 10 EX/MEM ALU result; 11 never driven.
REQ-009 pcWrite / ifidWrite  output  1 each  enable fetch PC and IF/ID register update; 0 holds them.
REQ-010 idexBubble  output  1  load a NOP into ID/EX next edge.
REQ-011 ifidFlush  output  1  clear IF/ID next edge.
REQ-012 stallCount / flushCount  output  32 each  performance counters.

Function
REQ-013 Shadow pipeline SHALL track ID/EX {valid, rs1, rs2, rd, regWrite, memRead}, EX/MEM {rd, regWrite, memRead} and MEM/WB {rd, regWrite}, advancing one stage per clock.
REQ-014 forwardA SHALL be 10 when EX/MEM.regWrite, EX/MEM.rd != 0 and EX/MEM.rd == ID/EX.rs1; else 01 when MEM/WB.regWrite, MEM/WB.rd != 0 and MEM/WB.rd == ID/EX.rs1; else 00.
REQ-015 forwardB SHALL follow REQ-014 using ID/EX.rs2.
REQ-016 EX/MEM match SHALL take priority over MEM/WB match for the same register.
REQ-017 forwardA/forwardB SHALL be 00 whenever ID/EX.valid is 0.
REQ-018 Forward outputs SHALL be combinational from registered shadow state only (zero added latency, no dependence on id_* inputs).
REQ-019 Load-use stall SHALL assert when id_valid, ID/EX.memRead, ID/EX.rd != 0 and ID/EX.rd equals id_rs1 or id_rs2.
REQ-020 During stall: pcWrite=0, ifidWrite=0, idexBubble=1; ID/EX shadow loads a bubble (all flags 0) while EX/MEM and MEM/WB advance normally.
REQ-021 A stall SHALL last exactly one cycle per load-use pair; the dependent instruction then receives forward 01 from the load in MEM/WB.
REQ-022 On ex_branchTaken: ifidFlush=1, idexBubble=1, pcWrite=1, ifidWrite=1; ID/EX shadow loads a bubble.
REQ-023 ex_branchTaken SHALL override a simultaneous load-use stall (no stall asserted, stallCount not incremented).
REQ-024 With neither event, pcWrite=ifidWrite=1, idexBubble=ifidFlush=0, and ID/EX shadow captures id_* (valid=id_valid).
REQ-025 stallCount SHALL increment on each stall cycle, flushCount on each ex_branchTaken cycle; both saturate at 0xFFFFFFFF.
REQ-026 Writes to x0 SHALL never produce forwarding or a stall.

Reset
REQ-027 While rst_n=0, all shadow stages SHALL be bubbles, counters 0, forwardA=forwardB=00, pcWrite=ifidWrite=1, idexBubble=ifidFlush=0.
REQ-028 Reset asserted mid-stall or mid-flush SHALL clear state immediately, asynchronously; the first edge after release SHALL behave as REQ-024.

Structure
REQ-029 Shared package SHALL hold constants FWD_RF=00, FWD_WB=01, FWD_EM=10 and the register-index width (5).
REQ-030 One combinational sub-module fwd_sel (one source index in, 2-bit select out) SHALL be instantiated twice, for A and B.

Verification
REQ-031 add x5 in EX/MEM, next instr rs1=5 in ID/EX -> forwardA=10, forwardB=00.
REQ-032 x7 written by both EX/MEM and MEM/WB, ID/EX rs2=7 -> forwardB=10; with only MEM/WB rd=7 -> 01.
REQ-033 ld x3 in ID/EX, id_rs2=3 -> one cycle stall (pcWrite=0, idexBubble=1), stallCount=1; next cycle forwardB=01.
REQ-034 Load-use condition with ex_branchTaken=1 same cycle -> ifidFlush=1, pcWrite=1, stallCount unchanged, flushCount=1.
REQ-035 EX/MEM rd=0 with regWrite=1, ID/EX rs1=0 -> forwardA=00; ld x0 followed by use of x0 -> no stall.
REQ-036 Force stallCount to 0xFFFFFFFF, trigger stall -> stays 0xFFFFFFFF; assert rst_n=0 mid-stall -> outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types and constants for the hazard/forwarding unit.
// Shadow-pipeline stage bundles and operand-select encodings.
package hazard_fwd_unit_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_EM = 2'b10;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    logic     rw;
    logic     mr;
  } id_ex_t;

  typedef struct packed {
    reg_idx_t rd;
    logic     rw;
    logic     mr;
  } ex_mem_t;

  typedef struct packed {
    reg_idx_t rd;
    logic     rw;
  } mem_wb_t;

  localparam id_ex_t  ID_EX_NOP  = '0;
  localparam ex_mem_t EX_MEM_NOP = '0;
  localparam mem_wb_t MEM_WB_NOP = '0;

endpackage

// File: rtl/hazard_fwd_unit_fwd_sel.sv
// Operand forwarding select for one execute-stage source register.
// EX/MEM result wins over MEM/WB; x0 never forwards.
module fwd_sel
  import hazard_fwd_unit_pkg::*;
(
  input  logic       src_valid_i,
  input  reg_idx_t   src_idx_i,
  input  reg_idx_t   em_rd_i,
  input  logic       em_rw_i,
  input  reg_idx_t   wb_rd_i,
  input  logic       wb_rw_i,
  output logic [1:0] sel_o
);

  logic em_hit;
  logic wb_hit;

  assign em_hit = em_rw_i && (em_rd_i != '0)
               && (em_rd_i == src_idx_i);
  assign wb_hit = wb_rw_i && (wb_rd_i != '0)
               && (wb_rd_i == src_idx_i);

  always_comb begin
    sel_o = FWD_RF;
    if (src_valid_i) begin
      priority case (1'b1)
        em_hit:  sel_o = FWD_EM;
        wb_hit:  sel_o = FWD_WB;
        default: sel_o = FWD_RF;
      endcase
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding control for a 5-stage pipeline.
// Tracks a shadow of ID/EX, EX/MEM, MEM/WB to drive stalls/flushes.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_regWrite,
  input  logic        id_memRead,
  input  logic        ex_branchTaken,
  output logic [1:0]  forwardA,
  output logic [1:0]  forwardB,
  output logic        pcWrite,
  output logic        ifidWrite,
  output logic        idexBubble,
  output logic        ifidFlush,
  output logic [31:0] stallCount,
  output logic [31:0] flushCount
);

  id_ex_t      idex_q,  idex_d;
  ex_mem_t     exmem_q, exmem_d;
  mem_wb_t     memwb_q, memwb_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  logic flush;
  logic luse;
  logic stall;
  logic unused_mr;

  assign unused_mr = exmem_q.mr;

  // Outputs must hold reset values while rst_n is low, even if a
  // branch is reported, so the flush is qualified by rst_n.
  assign flush = ex_branchTaken && rst_n;
  assign luse  = id_valid && idex_q.mr && (idex_q.rd != '0)
              && ((idex_q.rd == id_rs1) || (idex_q.rd == id_rs2));
  assign stall = luse && !flush;

  assign pcWrite    = !stall;
  assign ifidWrite  = !stall;
  assign idexBubble = stall || flush;
  assign ifidFlush  = flush;

  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;

  always_comb begin
    idex_d       = '{valid: id_valid, rs1: id_rs1, rs2: id_rs2,
                     rd: id_rd, rw: id_regWrite, mr: id_memRead};
    exmem_d      = '{rd: idex_q.rd, rw: idex_q.rw, mr: idex_q.mr};
    memwb_d      = '{rd: exmem_q.rd, rw: exmem_q.rw};
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (stall || flush) idex_d = ID_EX_NOP;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q      <= ID_EX_NOP;
      exmem_q     <= EX_MEM_NOP;
      memwb_q     <= MEM_WB_NOP;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      exmem_q     <= exmem_d;
      memwb_q     <= memwb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  fwd_sel u_fwd_a (
    .src_valid_i (idex_q.valid),
    .src_idx_i   (idex_q.rs1),
    .em_rd_i     (exmem_q.rd),
    .em_rw_i     (exmem_q.rw),
    .wb_rd_i     (memwb_q.rd),
    .wb_rw_i     (memwb_q.rw),
    .sel_o       (forwardA)
  );

  fwd_sel u_fwd_b (
    .src_valid_i (idex_q.valid),
    .src_idx_i   (idex_q.rs2),
    .em_rd_i     (exmem_q.rd),
    .em_rw_i     (exmem_q.rw),
    .wb_rd_i     (memwb_q.rd),
    .wb_rw_i     (memwb_q.rw),
    .sel_o       (forwardB)
  );

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed self-checking bench for hazard_fwd_unit.
// One task per scenario; expected values are hand-derived.
module tb_hazard_fwd_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_regWrite, id_memRead;
  logic        ex_branchTaken;
  logic [1:0]  forwardA, forwardB;
  logic        pcWrite, ifidWrite, idexBubble, ifidFlush;
  logic [31:0] stallCount, flushCount;

  int pass_cnt = 0;
  int total    = 0;

  hazard_fwd_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .id_regWrite    (id_regWrite),
    .id_memRead     (id_memRead),
    .ex_branchTaken (ex_branchTaken),
    .forwardA       (forwardA),
    .forwardB       (forwardB),
    .pcWrite        (pcWrite),
    .ifidWrite      (ifidWrite),
    .idexBubble     (idexBubble),
    .ifidFlush      (ifidFlush),
    .stallCount     (stallCount),
    .flushCount     (flushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic mr,
                       input logic br);
    id_valid       = v;
    id_rs1         = rs1;
    id_rs2         = rs2;
    id_rd          = rd;
    id_regWrite    = rw;
    id_memRead     = mr;
    ex_branchTaken = br;
    #1;
  endtask

  task automatic drain;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    total++;
    if ({forwardA, forwardB, pcWrite, ifidWrite, idexBubble, ifidFlush}
        !== 8'b0000_1100)
      $display("FAIL reset_ctrl got %b%b%b%b%b%b exp 00001100",
               forwardA, forwardB, pcWrite, ifidWrite,
               idexBubble, ifidFlush);
    else pass_cnt++;
    total++;
    if ({stallCount, flushCount} !== 64'd0)
      $display("FAIL reset_cnt got %h/%h exp 0/0",
               stallCount, flushCount);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fwd_em;
    drive(1, 1, 2, 5, 1, 0, 0);
    tick();
    drive(1, 5, 6, 8, 1, 0, 0);
    tick();
    total++;
    if ({forwardA, forwardB} !== 4'b1000)
      $display("FAIL fwd_em got A=%b B=%b exp A=10 B=00",
               forwardA, forwardB);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_fwd_priority;
    drive(1, 1, 2, 7, 1, 0, 0);
    tick();
    drive(1, 3, 4, 7, 1, 0, 0);
    tick();
    drive(1, 9, 7, 10, 1, 0, 0);
    tick();
    total++;
    if ({forwardA, forwardB} !== 4'b0010)
      $display("FAIL fwd_prio got A=%b B=%b exp A=00 B=10",
               forwardA, forwardB);
    else pass_cnt++;
    drain();
    drive(1, 1, 2, 7, 1, 0, 0);
    tick();
    drive(1, 3, 4, 9, 1, 0, 0);
    tick();
    drive(1, 9, 7, 10, 1, 0, 0);
    tick();
    total++;
    if ({forwardA, forwardB} !== 4'b1001)
      $display("FAIL fwd_wb got A=%b B=%b exp A=10 B=01",
               forwardA, forwardB);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_invalid_idex;
    drive(1, 1, 2, 11, 1, 0, 0);
    tick();
    drive(0, 11, 11, 0, 0, 0, 0);
    tick();
    total++;
    if ({forwardA, forwardB} !== 4'b0000)
      $display("FAIL fwd_invalid got A=%b B=%b exp 00 00",
               forwardA, forwardB);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_load_use;
    drive(1, 1, 2, 3, 1, 1, 0);
    tick();
    drive(1, 1, 3, 4, 1, 0, 0);
    total++;
    if ({pcWrite, ifidWrite, idexBubble, ifidFlush} !== 4'b0010)
      $display("FAIL lu_stall got %b%b%b%b exp 0010",
               pcWrite, ifidWrite, idexBubble, ifidFlush);
    else pass_cnt++;
    tick();
    total++;
    if (stallCount !== 32'd1)
      $display("FAIL lu_cnt got %0d exp 1", stallCount);
    else pass_cnt++;
    total++;
    if ({pcWrite, idexBubble} !== 2'b10)
      $display("FAIL lu_one_cycle got pc=%b bub=%b exp 1 0",
               pcWrite, idexBubble);
    else pass_cnt++;
    tick();
    total++;
    if ({forwardA, forwardB} !== 4'b0001)
      $display("FAIL lu_fwd got A=%b B=%b exp 00 01",
               forwardA, forwardB);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_branch_override;
    drive(1, 1, 2, 3, 1, 1, 0);
    tick();
    drive(1, 3, 2, 4, 1, 0, 1);
    total++;
    if ({pcWrite, ifidWrite, idexBubble, ifidFlush} !== 4'b1111)
      $display("FAIL br_ctrl got %b%b%b%b exp 1111",
               pcWrite, ifidWrite, idexBubble, ifidFlush);
    else pass_cnt++;
    tick();
    total++;
    if ({stallCount, flushCount} !== {32'd1, 32'd1})
      $display("FAIL br_cnt got %0d/%0d exp 1/1",
               stallCount, flushCount);
    else pass_cnt++;
    drive(1, 4, 4, 5, 0, 0, 0);
    tick();
    total++;
    if ({forwardA, forwardB} !== 4'b0000)
      $display("FAIL br_bubble got A=%b B=%b exp 00 00",
               forwardA, forwardB);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_x0;
    drive(1, 1, 2, 0, 1, 0, 0);
    tick();
    drive(1, 0, 0, 6, 1, 0, 0);
    tick();
    total++;
    if ({forwardA, forwardB} !== 4'b0000)
      $display("FAIL x0_fwd got A=%b B=%b exp 00 00",
               forwardA, forwardB);
    else pass_cnt++;
    drain();
    drive(1, 1, 2, 0, 1, 1, 0);
    tick();
    drive(1, 0, 0, 6, 1, 0, 0);
    total++;
    if ({pcWrite, idexBubble} !== 2'b10)
      $display("FAIL x0_stall got pc=%b bub=%b exp 1 0",
               pcWrite, idexBubble);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_saturate_and_reset;
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    drive(1, 1, 2, 3, 1, 1, 0);
    tick();
    drive(1, 3, 2, 4, 1, 0, 0);
    tick();
    total++;
    if (stallCount !== 32'hFFFF_FFFF)
      $display("FAIL sat_cnt got %h exp ffffffff", stallCount);
    else pass_cnt++;
    drain();
    drive(1, 1, 2, 3, 1, 1, 0);
    tick();
    drive(1, 3, 2, 4, 1, 0, 0);
    total++;
    if (pcWrite !== 1'b0)
      $display("FAIL rst_pre got pc=%b exp 0", pcWrite);
    else pass_cnt++;
    ex_branchTaken = 1'b1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({forwardA, forwardB, pcWrite, ifidWrite, idexBubble, ifidFlush}
        !== 8'b0000_1100 || stallCount !== 32'd0
        || flushCount !== 32'd0)
      $display("FAIL rst_async got %b%b%b%b%b%b cnt %h/%h exp 00001100 0/0",
               forwardA, forwardB, pcWrite, ifidWrite,
               idexBubble, ifidFlush, stallCount, flushCount);
    else pass_cnt++;
    drive(1, 1, 2, 5, 1, 0, 0);
    #2;
    rst_n = 1'b1;
    tick();
    total++;
    if ({pcWrite, ifidWrite, idexBubble, ifidFlush} !== 4'b1100)
      $display("FAIL rst_release got %b%b%b%b exp 1100",
               pcWrite, ifidWrite, idexBubble, ifidFlush);
    else pass_cnt++;
    drive(1, 5, 5, 6, 1, 0, 0);
    tick();
    total++;
    if ({forwardA, forwardB} !== 4'b1010)
      $display("FAIL rst_capture got A=%b B=%b exp 10 10",
               forwardA, forwardB);
    else pass_cnt++;
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_fwd_em();
    test_fwd_priority();
    test_invalid_idex();
    test_load_use();
    test_branch_override();
    test_x0();
    test_saturate_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
